// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word RAM, one 8-bit IO register and a free-running cycle counter behind a processor load/store port.
// Latency: stores commit at the sampling edge with no stall; loads stall 2 cycles and return data combinationally in the 3rd.
// Backpressure: stall = MRE & ~MWE & (state != RD_DONE); a dropped MRE or a raised MWE in RD_WAIT abandons the load.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low
//   memdir     - byte address (ALU result)
//   memdataout - store data
//   MRE / MWE  - level read / write requests
//   memdatain  - load data back to the processor
//   stall      - processor hold
//   io_out     - memory-mapped output register
//   fault      - sticky access-error flag
module data_mem_ctrl #(
  parameter int bus   = 32,
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [bus-1:0] memdir,
  input  logic [bus-1:0] memdataout,
  input  logic           MRE,
  input  logic           MWE,
  output logic [bus-1:0] memdatain,
  output logic           stall,
  output logic [7:0]     io_out,
  output logic           fault
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_DONE = 2'd2;

  localparam logic [bus-1:0] IO_ADDR  = bus'(32'hFFFF_0000);
  localparam logic [bus-1:0] CNT_ADDR = bus'(32'hFFFF_0004);

  logic [1:0]     state_q,     state_d;
  logic [bus-1:0] addr_q,      addr_d;
  logic [bus-1:0] rd_data_q,   rd_data_d;
  logic [bus-1:0] memdatain_q, memdatain_d;
  logic [7:0]     io_out_q,    io_out_d;
  logic           fault_q,     fault_d;
  logic [31:0]    cnt_q,       cnt_d;

  logic [bus-1:0] mem_q [DEPTH];
  logic           ram_we;

  // Store-side decode works on the live address.
  logic             w_aligned, w_ram, w_io, w_ok;
  logic [IDX_W-1:0] w_idx;

  assign w_aligned = (memdir[1:0] == 2'b00);
  assign w_ram     = (memdir[bus-1:16] == '0);
  assign w_io      = (memdir == IO_ADDR);
  assign w_ok      = w_aligned & (w_ram | w_io);
  assign w_idx     = memdir[IDX_W+1:2];

  // Load-side decode works on the address latched when the load started,
  // so the ALU result may change while the processor is stalled.
  logic             r_aligned, r_ram, r_io, r_cnt, r_ok;
  logic [IDX_W-1:0] r_idx;
  logic [bus-1:0]   r_val;

  assign r_aligned = (addr_q[1:0] == 2'b00);
  assign r_ram     = (addr_q[bus-1:16] == '0);
  assign r_io      = (addr_q == IO_ADDR);
  assign r_cnt     = (addr_q == CNT_ADDR);
  assign r_ok      = r_aligned & (r_ram | r_io | r_cnt);
  assign r_idx     = addr_q[IDX_W+1:2];

  always_comb begin
    r_val = bus'(cnt_q);
    if (r_ram) begin
      r_val = mem_q[r_idx];
    end else if (r_io) begin
      r_val = {{(bus-8){1'b0}}, io_out_q};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_data_d   = rd_data_q;
    memdatain_d = memdatain_q;
    io_out_d    = io_out_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q + 32'd1;
    ram_we      = 1'b0;

    // Stores commit immediately; a simultaneous MRE is a processor error
    // that still lets the store through but is flagged.
    if (MWE) begin
      if (w_ok) begin
        if (w_ram) begin
          ram_we = 1'b1;
        end else begin
          io_out_d = memdataout[7:0];
        end
      end
      if (!w_ok || MRE) begin
        fault_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (MRE && !MWE) begin
          addr_d  = memdir;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Once the request goes away the load is dead: leave the result
        // register and fault untouched.
        if (!MRE || MWE) begin
          state_d = IDLE;
        end else begin
          state_d = RD_DONE;
          if (r_ok) begin
            rd_data_d = r_val;
          end else begin
            rd_data_d = '0;
            fault_d   = 1'b1;
          end
        end
      end
      RD_DONE: begin
        memdatain_d = rd_data_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_data_q   <= '0;
      memdatain_q <= '0;
      io_out_q    <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_data_q   <= rd_data_d;
      memdatain_q <= memdatain_d;
      io_out_q    <= io_out_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[w_idx] <= memdataout;
    end
  end

  // The result is presented during RD_DONE so the processor captures it at
  // the end of that cycle; afterwards the held copy keeps it stable.
  assign memdatain = (state_q == RD_DONE) ? rd_data_q : memdatain_q;
  assign stall     = MRE & ~MWE & (state_q != RD_DONE);
  assign io_out    = io_out_q;
  assign fault     = fault_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter: bus, 32, data/address width.
REQ-002 SHALL have parameter: DEPTH, 256, RAM depth in 32-bit words (power of two).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: memdir  input  bus  byte address from processor ALU result.
REQ-006 SHALL have port: memdataout  input  bus  store data from processor.
REQ-007 SHALL have port: MRE  input  1  processor read request, level.
REQ-008 SHALL have port: MWE  input  1  processor write request, level.
REQ-009 SHALL have port: memdatain  output  bus  load data returned to processor.
REQ-010 SHALL have port: stall  output  1  processor hold; PC/regs frozen while high.
REQ-011 SHALL have port: io_out  output  8  memory-mapped output register.
REQ-012 SHALL have port: fault  output  1  sticky access-error flag.

Function
REQ-013 SHALL decode the address map as: memdir[31:16]==0 -> RAM, word index memdir[log2(DEPTH)+1:2]; 0xFFFF0000 -> IO register (R/W, bits [7:0], upper bits read 0); 0xFFFF0004 -> cycle counter (read-only); all other addresses -> unmapped.
REQ-014 SHALL treat any access with memdir[1:0]!=0, or to an unmapped address, as a fault: set fault, suppress the write, and return 0 on the read, which still completes through the FSM.
REQ-015 SHALL perform writes in the cycle MWE is sampled high: RAM word or io_out updated at that edge; stall stays 0; RAM contents beyond index bits ignore the upper address bits.
REQ-016 SHALL ignore writes to the cycle counter address, which sets fault.
REQ-017 SHALL implement the read FSM states IDLE, RD_WAIT, RD_DONE.
REQ-018 SHALL on IDLE with MRE=1 and MWE=0 latch memdir and go to RD_WAIT.
REQ-019 SHALL in RD_WAIT perform the registered RAM/IO/counter read at the latched address and go to RD_DONE.
REQ-020 SHALL in RD_DONE drive the read result on memdatain and return to IDLE.
REQ-021 SHALL drive stall = MRE & ~MWE & (state != RD_DONE), combinationally, so a load stalls exactly 2 cycles and completes in the 3rd.
REQ-022 SHALL abort to IDLE without updating memdatain if MRE drops in RD_WAIT.
REQ-023 SHALL hold memdatain at the last completed read value outside RD_DONE.
REQ-024 SHALL give MWE priority when MRE and MWE are both high: do a write, no stall, set fault.
REQ-025 SHALL keep the cycle counter as a 32-bit free-running counter, incrementing every cycle and wrapping 0xFFFFFFFF -> 0; a read returns the value sampled in RD_WAIT.
REQ-026 SHALL keep fault sticky until reset.
REQ-027 SHALL ignore memdir changes during RD_WAIT and RD_DONE, using the latched address.

Reset
REQ-028 SHALL, while reset=0, force state=IDLE, memdatain=0, io_out=0, fault=0, cycle counter=0, and latched address=0, asynchronously; stall SHALL then follow REQ-021 (IDLE), and RAM contents are not reset.
REQ-029 SHALL, if reset is asserted mid-read, abandon the read; after release, a still-high MRE starts a fresh read from IDLE.

Verification
REQ-030 SHALL be tested with: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> stall high 2 cycles, memdatain=0xDEADBEEF in the 3rd cycle, fault=0.
REQ-031 SHALL be tested with: write 0x000001A5 to 0xFFFF0000 -> io_out=0xA5 next edge; read back -> 0x000000A5.
REQ-032 SHALL be tested with: read 0x00000013 (misaligned) -> fault=1, memdatain=0 in RD_DONE; fault stays 1 until reset=0.
REQ-033 SHALL be tested with: MRE and MWE both high at 0x00000020 with data 0x12345678 -> stall=0, RAM[8]=0x12345678, fault=1.
REQ-034 SHALL be tested with: MRE dropped in RD_WAIT -> return to IDLE, memdatain unchanged; reset=0 asserted in RD_WAIT -> state IDLE, io_out=0, memdatain=0 immediately.
REQ-035 SHALL be tested with: counter preloaded via force to 0xFFFFFFFE, read 0xFFFF0004 -> value sampled in RD_WAIT returned; counter wraps to 0 within 2 cycles.
